// File: rtl/serial_result_collector_pkg.sv
// Shared definitions for the serial result collector.
// Contents: FSM state encoding, default width/latency, counter width helper.
package serial_result_collector_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StShift = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam int unsigned DefaultW   = 8;
  localparam int unsigned DefaultLat = 1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_result_collector_bit_counter.sv
// Saturating up-counter with synchronous clear, load and enable.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_clr           clear to zero
//   i_load          load i_load_val (lower priority than clear)
//   i_en            count up by one; holds once the terminal value is reached
//   o_tc            counter equals Last
module serial_result_collector_bit_counter #(
  parameter int unsigned Width = 1,
  parameter int unsigned Last  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [Width-1:0] r_cnt;

  assign o_tc = (r_cnt == Width'(Last));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_result_collector.sv
// Collects an LSB-first serial result into a parallel word after a fixed
// pipeline delay and offers it on a valid/ready handshake.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        one-cycle pulse starting a capture
//   i_s_in         serial result bit, LSB first
//   i_out_ready    consumer accepts o_p_out while o_p_valid is high
//   o_p_out        assembled word
//   o_p_valid      o_p_out holds a complete result
//   o_busy         capture in progress (waiting or shifting)
//   o_overrun      one-cycle pulse when a start was dropped
module serial_result_collector
  import serial_result_collector_pkg::*;
#(
  parameter int unsigned W   = DefaultW,
  parameter int unsigned LAT = DefaultLat
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_s_in,
  input  logic         i_out_ready,
  output logic [W-1:0] o_p_out,
  output logic         o_p_valid,
  output logic         o_busy,
  output logic         o_overrun
);

  localparam int unsigned BitCntW = cnt_width(W);
  localparam int unsigned DlyCntW = cnt_width(LAT);
  localparam int unsigned DlyLast = (LAT > 0) ? LAT - 1 : 0;

  state_e       r_state, w_state_next;
  logic [W-1:0] r_sr, r_p_out, w_sr_shifted;
  logic         r_p_valid, r_busy, r_overrun;
  logic         w_start_ok, w_sample, w_first, w_final, w_overrun_next;
  logic         w_dly_clr, w_dly_en, w_dly_tc;
  logic         w_bit_load, w_bit_en, w_bit_tc;

  generate
    if (W == 1) begin : g_w1
      assign w_sr_shifted = i_s_in;
    end else begin : g_wn
      assign w_sr_shifted = {i_s_in, r_sr[W-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_next   = r_state;
    w_start_ok     = 1'b0;
    w_sample       = 1'b0;
    w_first        = 1'b0;
    w_overrun_next = 1'b0;
    w_dly_clr      = 1'b0;
    w_dly_en       = 1'b0;
    w_bit_load     = 1'b0;
    w_bit_en       = 1'b0;

    unique case (r_state)
      StIdle: w_start_ok = i_start;
      StWait: begin
        w_overrun_next = i_start;
        // Terminal delay count: this edge already carries bit 0.
        if (w_dly_tc) begin
          w_sample = 1'b1;
          w_first  = 1'b1;
        end else begin
          w_dly_en = 1'b1;
        end
      end
      StShift: begin
        w_overrun_next = i_start;
        w_sample       = 1'b1;
      end
      StHold: begin
        if (i_out_ready) begin
          w_state_next = StIdle;
          w_start_ok   = i_start;
        end else begin
          w_overrun_next = i_start;
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_start_ok) begin
      if (LAT == 0) begin
        w_sample = 1'b1;
        w_first  = 1'b1;
      end else begin
        w_state_next = StWait;
        w_dly_clr    = 1'b1;
      end
    end

    // Bit counter holds the index of the bit being sampled while shifting.
    w_final = w_sample && (w_first ? (W == 1) : w_bit_tc);

    if (w_sample) begin
      if (w_final) begin
        w_state_next = StHold;
      end else begin
        w_state_next = StShift;
        w_bit_load   = w_first;
        w_bit_en     = !w_first;
      end
    end
  end

  serial_result_collector_bit_counter #(
    .Width(DlyCntW),
    .Last (DlyLast)
  ) u_dly_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_dly_clr),
    .i_load    (1'b0),
    .i_load_val('0),
    .i_en      (w_dly_en),
    .o_tc      (w_dly_tc)
  );

  serial_result_collector_bit_counter #(
    .Width(BitCntW),
    .Last (W - 1)
  ) u_bit_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (1'b0),
    .i_load    (w_bit_load),
    .i_load_val(BitCntW'(1)),
    .i_en      (w_bit_en),
    .o_tc      (w_bit_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_sr      <= '0;
      r_p_out   <= '0;
      r_p_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_sample) r_sr <= w_sr_shifted;
      if (w_final) r_p_out <= w_sr_shifted;
      // A final bit arriving with a handoff keeps valid high (W=1, LAT=0).
      if (w_final) begin
        r_p_valid <= 1'b1;
      end else if (r_state == StHold && i_out_ready) begin
        r_p_valid <= 1'b0;
      end
      r_busy    <= (w_state_next == StWait) || (w_state_next == StShift);
      r_overrun <= w_overrun_next;
    end
  end

  assign o_p_out   = r_p_out;
  assign o_p_valid = r_p_valid;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_serial_result_collector.sv
// Self-checking bench for serial_result_collector (W=8/LAT=1 and W=1/LAT=0).
module tb_serial_result_collector;

  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1, start = 1'b0, s_in = 1'b0, out_ready = 1'b0;
  logic [W-1:0] p_out;
  logic         p_valid, busy, overrun;

  logic         d1_start = 1'b0, d1_s_in = 1'b0, d1_ready = 1'b0;
  logic [0:0]   d1_p_out;
  logic         d1_valid, d1_busy, d1_overrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_result_collector #(.W(W), .LAT(LAT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_s_in     (s_in),
    .i_out_ready(out_ready),
    .o_p_out    (p_out),
    .o_p_valid  (p_valid),
    .o_busy     (busy),
    .o_overrun  (overrun)
  );

  serial_result_collector #(.W(1), .LAT(0)) dut1 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (d1_start),
    .i_s_in     (d1_s_in),
    .i_out_ready(d1_ready),
    .o_p_out    (d1_p_out),
    .o_p_valid  (d1_valid),
    .o_busy     (d1_busy),
    .o_overrun  (d1_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a capture accepted at edge cs takes its bits from the
  // s_in values seen at edges cs+LAT .. cs+LAT+W-1.
  bit         hist [8192];
  int         cyc = 0;
  int         m_cs = 0;
  bit         m_cap = 0, m_hold = 0, m_ovr = 0;
  logic [W-1:0] m_word = '0;

  task automatic model_finish();
    for (int k = 0; k < int'(W); k++) m_word[k] = hist[m_cs + int'(LAT) + k];
    m_hold = 1;
    m_cap  = 0;
  endtask

  task automatic model_edge(input bit st, input bit sin, input bit rdy, input bit rs);
    bit acc;
    hist[cyc] = sin;
    if (rs) begin
      m_cap = 0; m_hold = 0; m_ovr = 0; m_word = '0;
    end else begin
      acc   = st && !m_cap && (!m_hold || rdy);
      m_ovr = st && !acc;
      if (m_hold && rdy) m_hold = 0;
      if (m_cap && cyc == m_cs + int'(LAT + W) - 1) model_finish();
      if (acc) begin
        m_cs  = cyc;
        m_cap = 1;
        if (LAT + W == 1) model_finish();
      end
    end
    cyc++;
  endtask

  task automatic step(input bit st, input bit sin, input bit rdy, input bit rs);
    start = st; s_in = sin; out_ready = rdy; rst = rs;
    @(posedge clk);
    #1;
    model_edge(st, sin, rdy, rs);
    chk("model p_valid", p_valid, m_hold);
    chk("model p_out", p_out, m_word);
    chk("model busy", busy, m_cap);
    chk("model overrun", overrun, m_ovr);
  endtask

  task automatic capture_bits(input logic [W-1:0] v);
    for (int k = 0; k < int'(W); k++) step(0, v[k], 0, 0);
  endtask

  typedef struct {
    bit st, sin, rdy, rs;
    bit ev;
    logic [W-1:0] epo;
    bit eb, eo;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit st, input bit sin, input bit rdy, input bit rs,
                         input bit ev, input logic [W-1:0] epo, input bit eb, input bit eo);
    vec_t v;
    v.st = st; v.sin = sin; v.rdy = rdy; v.rs = rs;
    v.ev = ev; v.epo = epo; v.eb = eb; v.eo = eo;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] pat;

    // Directed table: reset, capture 0xA5, hold five cycles, hand off.
    pat = 8'hA5;
    add_vec(0, 0, 0, 1, 0, 8'h00, 0, 0);
    add_vec(1, 0, 0, 0, 0, 8'h00, 1, 0);
    for (int k = 0; k < 8; k++)
      add_vec(0, pat[k], 0, 0, k == 7, (k == 7) ? pat : 8'h00, k < 7, 0);
    for (int k = 0; k < 5; k++) add_vec(0, 1, 0, 0, 1, 8'hA5, 0, 0);
    add_vec(0, 0, 1, 0, 0, 8'hA5, 0, 0);
    add_vec(0, 1, 1, 0, 0, 8'hA5, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].sin, vecs[i].rdy, vecs[i].rs);
      chk($sformatf("vec%0d p_valid", i), p_valid, vecs[i].ev);
      chk($sformatf("vec%0d p_out", i), p_out, vecs[i].epo);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].eb);
      chk($sformatf("vec%0d overrun", i), overrun, vecs[i].eo);
    end

    // Back-to-back: handoff and new start on the same edge.
    step(1, 0, 0, 0);
    capture_bits(8'hA5);
    chk("b2b first valid", p_valid, 1);
    chk("b2b first word", p_out, 8'hA5);
    step(1, 0, 1, 0);
    chk("b2b handoff valid", p_valid, 0);
    chk("b2b restart busy", busy, 1);
    pat = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      step(0, pat[k], 0, 0);
      if (k < 7) chk($sformatf("b2b early valid %0d", k), p_valid, 0);
    end
    chk("b2b second valid", p_valid, 1);
    chk("b2b second word", p_out, 8'h3C);
    step(0, 0, 1, 0);

    // Overrun: a start three bits into the shift is dropped.
    pat = 8'hA5;
    step(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(k == 3, pat[k], 0, 0);
      if (k == 3) chk("overrun pulse", overrun, 1);
      if (k == 4) chk("overrun one cycle", overrun, 0);
    end
    chk("overrun word", p_out, 8'hA5);
    chk("overrun valid", p_valid, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("overrun no extra busy", busy, 0);
    chk("overrun no extra valid", p_valid, 0);

    // Reset after bit 4, then a fresh 0xFF capture.
    step(1, 0, 0, 0);
    capture_bits(8'h00);
    chk("hold before rst", p_valid, 1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("rst p_out", p_out, 0);
    chk("rst p_valid", p_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    step(1, 0, 0, 0);
    capture_bits(8'hFF);
    chk("post-rst word", p_out, 8'hFF);
    chk("post-rst valid", p_valid, 1);
    step(0, 0, 1, 0);

    // W=1, LAT=0 corner.
    d1_start = 1; d1_s_in = 1; d1_ready = 0;
    step(0, 0, 0, 0);
    chk("w1 valid", d1_valid, 1);
    chk("w1 word", d1_p_out, 1);
    chk("w1 busy", d1_busy, 0);
    d1_start = 1; d1_s_in = 0; d1_ready = 0;
    step(0, 0, 0, 0);
    chk("w1 overrun", d1_overrun, 1);
    chk("w1 word kept", d1_p_out, 1);
    d1_start = 1; d1_s_in = 0; d1_ready = 1;
    step(0, 0, 0, 0);
    chk("w1 b2b valid", d1_valid, 1);
    chk("w1 b2b word", d1_p_out, 0);
    chk("w1 b2b overrun", d1_overrun, 0);
    d1_start = 0; d1_s_in = 1; d1_ready = 1;
    step(0, 0, 0, 0);
    chk("w1 drained", d1_valid, 0);
    d1_ready = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_result_collector.md
Name: serial_result_collector

Overview:
- Receiving end of the LSB-first serial bit stream produced by the serial adder/multiplier datapath.
- Samples a W-bit serial result after a programmable pipeline delay.
- Assembles the bits into a parallel word and presents it on a valid/ready output handshake.
- Sits between the serial-parallel multiplier output and any parallel consumer (register file, test harness).

Parameters:
- W, 8, result width in bits (>= 1).
- LAT, 1, cycles from the start pulse to bit 0 appearing on s_in (0 = bit 0 arrives in the same cycle as start). Covers the flip-flop delay of the serial sum stage.

Ports:
- clk  input  1  global clock, rising edge.
- rst  input  1  global reset, synchronous, active-high.
- start  input  1  one-cycle pulse marking the start of a serial result.
- s_in  input  1  serial result bit, LSB first.
- out_ready  input  1  consumer accepts p_out when high while p_valid is high.
- p_out  output  W  assembled parallel result.
- p_valid  output  1  p_out holds a complete result.
- busy  output  1  high in WAIT or SHIFT.
- overrun  output  1  one-cycle pulse when a start is dropped.

Behaviour:
- Reset: on a clk edge with rst=1, all of the following are cleared: state=IDLE, p_out=0, p_valid=0, busy=0, overrun=0, shift register=0, counters=0. Reset mid-capture abandons the word; no partial result is ever presented.
- FSM states and transitions:
  - IDLE: start with LAT>0 -> WAIT, delay counter loaded with LAT-1.
  - IDLE: start with LAT=0 -> s_in sampled as bit 0 on the same edge; go to SHIFT, or to HOLD directly if W=1.
  - WAIT: counter decrements each cycle. At 0, go to SHIFT; bit 0 is sampled at edge E0+LAT, where E0 is the edge that sampled start.
  - SHIFT: each edge shifts s_in in at the MSB: sr <= {s_in, sr[W-1:1]}. A bit counter counts 0..W-1. Bit k is sampled at edge E0+LAT+k.
  - SHIFT, final bit: on the edge sampling bit W-1, p_out <= {s_in, sr[W-1:1]} and p_valid <= 1; go to HOLD. Latency from start to p_valid is LAT+W cycles (p_valid is visible after edge E0+LAT+W-1).
  - HOLD: p_out is stable while p_valid=1. out_ready=1 -> p_valid=0 next cycle; go to IDLE.
- Simultaneous events and boundaries:
  - HOLD with out_ready=1 and start=1: the word is handed off and the new capture begins on the same edge, exactly as if from IDLE.
  - start while in WAIT or SHIFT: ignored, overrun=1 for one cycle, and the capture in progress is unaffected.
  - start in HOLD with out_ready=0: ignored, overrun=1 for one cycle, and p_out is retained.
  - out_ready while p_valid=0: no effect.
- Widths and values:
  - Bit counter width is clog2(W), minimum 1; it never exceeds W-1 and does not wrap.
  - p_out is an unsigned raw bit pattern with no sign handling.
  - s_in is ignored outside SHIFT (and outside the LAT=0 start cycle).

Decomposition:
- Shared constants file (alongside the global numerics include):
  - FSM state encodings: IDLE=2'd0, WAIT=2'd1, SHIFT=2'd2, HOLD=2'd3.
  - Default W and LAT.
- Sub-module bit_counter: parameterized up-counter with synchronous clear, load, enable and terminal-count flag. It is instantiated twice, once for the delay count and once for the bit count.
- Reuse the existing d_flip_flop for the single-bit registered outputs (busy, overrun).

Test Plan:
- W=8, LAT=1: pulse start at edge 0, drive bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1) on edges 1..8 -> p_valid=1 and p_out=0xA5 after edge 8; busy=1 after edges 0..7.
- Hold test: out_ready=0 for 5 cycles after p_valid -> p_out stays 0xA5, p_valid stays 1; then out_ready=1 -> p_valid=0 next cycle, state IDLE.
- Back-to-back: in HOLD, assert out_ready=1 and start=1 together, stream 0x3C -> 0xA5 is accepted, then p_out=0x3C, p_valid=1 exactly LAT+W=9 cycles after the second start.
- Overrun: a second start 3 cycles into SHIFT -> overrun pulses high for one cycle, result still 0xA5, no extra capture follows.
- Reset mid-operation: assert rst after bit 4 of a capture -> next cycle all outputs are 0, state IDLE; a fresh start with 0xFF yields p_out=0xFF.
- Parameter corner: W=1, LAT=0, start with s_in=1 -> p_valid=1 and p_out=1 after the same edge.
